cpu_eu_fetch_seq: RTL and testbench
===================================

// Module: cpu_eu_fetch_seq
// PURPOSE
//  Parametrised program-counter/instruction-register/address unit for the execution unit.
//  Fetches instructions over a req/rdy memory handshake, with a programmable timeout.
//  Selects the PC source (ALU result or PC-relative branch) and drives the memory address mux.
//  Optional link stack provides call/return. Sits between control unit, Integer_Datapath and memory.
// PARAMETERS
//  DW        16  data/address/PC/IR width
//  IMM_W      8  branch offset width, IR_out[IMM_W-1:0], sign-extended; 1 <= IMM_W <= DW
//  RST_PC     0  PC value after reset
//  INC        1  PC increment step (fetch completion and pc_inc)
//  TIMEOUT   15  max wait cycles in FETCH; 0 = never time out
//  STK_DEPTH  4  link-stack entries (power of 2, >= 2); used only with LINK_STACK_EN
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   synchronous, active-high
//  ir_ld      in   1   start instruction fetch (accepted in IDLE only)
//  pc_ld      in   1   load PC from source chosen by pc_sel
//  pc_inc     in   1   PC <= PC + INC
//  pc_sel     in   1   1: Alu_out, 0: PC + sext(IR_out[IMM_W-1:0])
//  adr_sel    in   1   addr source in IDLE: 1 Reg_out, 0 PC
//  push       in   1   call: push current PC onto link stack
//  pop        in   1   return: PC <= top of stack
//  Alu_out    in   DW  ALU result (jump target)
//  Reg_out    in   DW  register operand (data address)
//  D_in       in   DW  memory read data
//  mem_rdy    in   1   memory completes request this cycle
//  mem_req    out  1   fetch request outstanding
//  addr       out  DW  memory address
//  PC         out  DW  program counter
//  IR_out     out  DW  instruction register
//  busy       out  1   state == FETCH
//  fetch_err  out  1   one-cycle pulse on timeout
//  stk_empty  out  1   link stack empty
//  stk_full   out  1   link stack full
//  stk_err    out  1   one-cycle pulse: pop on empty or push+pop same cycle
// BEHAVIOUR
//  Reset (sync, overrides all): state IDLE, PC=RST_PC, IR_out=0, wait count=0, stack empty;
//   mem_req=0, busy=0, fetch_err=0, stk_err=0, stk_empty=1, stk_full=0. Applies mid-fetch: request dropped.
//  FSM IDLE: ir_ld -> FETCH next cycle. FETCH: mem_req=1, busy=1, addr=PC (adr_sel ignored).
//  FETCH + mem_rdy: IR_out<=D_in, PC<=PC+INC, -> IDLE; IR visible 1 cycle after rdy edge.
//  Min latency ir_ld -> IR_out valid: 2 cycles (rdy in first FETCH cycle).
//  Wait counter counts FETCH cycles without rdy; when count reaches TIMEOUT (TIMEOUT>0):
//   -> IDLE, fetch_err pulse, IR_out and PC unchanged. mem_rdy on the timeout cycle wins (normal completion).
//  mem_rdy while IDLE ignored. ir_ld, pc_ld, pc_inc, push, pop ignored during FETCH (PC stable while addressed).
//  IDLE PC update priority: pc_ld > pop > pc_inc. Branch target = PC + sext(IR_out[IMM_W-1:0]).
//  All PC arithmetic modulo 2^DW (wraps silently, e.g. FFFF+1 = 0000).
//  IDLE addr = adr_sel ? Reg_out : PC (combinational).
//  Stack (IDLE only): push stores current PC (may combine with pc_ld = call).
//   Push when full: circular, oldest entry overwritten, stays full.
//   Pop when empty: PC unchanged, stk_err pulse. Push+pop same cycle: both ignored, stk_err pulse.
// CONFIGURATION
//  LINK_STACK_EN defined: link stack of STACK depth STK_DEPTH as above.
//  Not defined: no stack storage; push/pop ignored (pop does not change PC), stk_empty=1,
//   stk_full=0, stk_err=0 constant.
// TESTING (DW=16, IMM_W=8, INC=1, TIMEOUT=15, STK_DEPTH=4)
//  Reset then PC=0x0010 via Alu_out/pc_sel=1/pc_ld; ir_ld, rdy 3 cycles later, D_in=0xA5F3
//   -> mem_req 3 cycles, addr=0x0010, IR_out=0xA5F3, PC=0x0011.
//  IR_out=0x00FE, PC=0x0011, pc_ld pc_sel=0 -> PC=0x000F; IR_out=0x007F -> PC=0x0090; PC=0xFFFF pc_inc -> 0x0000.
//  ir_ld, mem_rdy never -> fetch_err pulses after 15 wait cycles, state IDLE, PC/IR unchanged.
//  reset asserted mid-FETCH -> next cycle mem_req=0, PC=RST_PC, IR_out=0, busy=0.
//  LINK_STACK_EN: push 5 times PC=1..5 -> stk_full; 4 pops give 5,4,3,2; 5th pop -> stk_err, PC unchanged.
//  adr_sel=1, Reg_out=0x1234 in IDLE -> addr=0x1234; same during FETCH -> addr=PC.

Source files
------------

// File: rtl/cpu_eu_fetch_seq.sv
// PC / IR / address unit: req/rdy instruction fetch with timeout, PC source select, memory address mux.
// Optional call/return link stack enabled by defining LINK_STACK_EN.
module cpu_eu_fetch_seq #(
    parameter int DW        = 16,
    parameter int IMM_W     = 8,
    parameter int RST_PC    = 0,
    parameter int INC       = 1,
    parameter int TIMEOUT   = 15,
    parameter int STK_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ir_ld,
    input  logic          pc_ld,
    input  logic          pc_inc,
    input  logic          pc_sel,
    input  logic          adr_sel,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] Alu_out,
    input  logic [DW-1:0] Reg_out,
    input  logic [DW-1:0] D_in,
    input  logic          mem_rdy,
    output logic          mem_req,
    output logic [DW-1:0] addr,
    output logic [DW-1:0] PC,
    output logic [DW-1:0] IR_out,
    output logic          busy,
    output logic          fetch_err,
    output logic          stk_empty,
    output logic          stk_full,
    output logic          stk_err
);

    // state   | meaning
    // S_IDLE  | PC/stack updates accepted, addr follows adr_sel
    // S_FETCH | mem_req held, addr = PC, waiting for mem_rdy or timeout
    typedef enum logic {S_IDLE, S_FETCH} state_t;

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t        state_q, state_d;
    logic [DW-1:0] pc_q, pc_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ferr_q, ferr_d;
    logic [DW-1:0] br_off;
    logic [DW-1:0] stk_top;
    logic          pop_pc;
    logic          idle;

    assign idle   = (state_q == S_IDLE);
    assign br_off = DW'($signed(ir_q[IMM_W-1:0]));

`ifdef LINK_STACK_EN
    localparam int SPW = $clog2(STK_DEPTH);

    logic [DW-1:0] stk_mem [STK_DEPTH];
    logic [SPW-1:0] stk_wp;
    logic [SPW:0]   stk_cnt;
    logic           stk_err_q;
    logic           do_push, do_pop, err_d;

    assign stk_empty = (stk_cnt == '0);
    assign stk_full  = (stk_cnt == (SPW+1)'(STK_DEPTH));
    assign stk_err   = stk_err_q;
    assign stk_top   = stk_mem[stk_wp - 1'b1];

    // A pop loses to pc_ld for the PC, so it leaves the stack untouched too.
    assign do_push = idle & push & ~pop;
    assign do_pop  = idle & pop & ~push & ~pc_ld & ~stk_empty;
    assign err_d   = idle & pop & (push | stk_empty);
    assign pop_pc  = do_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            stk_wp    <= '0;
            stk_cnt   <= '0;
            stk_err_q <= 1'b0;
        end else begin
            stk_err_q <= err_d;
            if (do_push) begin
                stk_wp <= stk_wp + 1'b1;
                if (!stk_full) stk_cnt <= stk_cnt + 1'b1;
            end else if (do_pop) begin
                stk_wp  <= stk_wp - 1'b1;
                stk_cnt <= stk_cnt - 1'b1;
            end
        end
    end

    // Circular write: when full, the slot at the write pointer holds the oldest entry.
    always_ff @(posedge clk) begin
        if (do_push) stk_mem[stk_wp] <= pc_q;
    end
`else
    logic unused_stk;

    assign stk_empty  = 1'b1;
    assign stk_full   = 1'b0;
    assign stk_err    = 1'b0;
    assign stk_top    = '0;
    assign pop_pc     = 1'b0;
    assign unused_stk = &{1'b0, push, pop, 1'(STK_DEPTH)};
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        ferr_d  = 1'b0;
        mem_req = 1'b0;
        busy    = 1'b0;
        addr    = adr_sel ? Reg_out : pc_q;
        case (state_q)
            S_IDLE: begin
                if (ir_ld) begin
                    state_d = S_FETCH;
                    cnt_d   = CW'(TIMEOUT);
                end
                if (pc_ld)       pc_d = pc_sel ? Alu_out : pc_q + br_off;
                else if (pop_pc) pc_d = stk_top;
                else if (pc_inc) pc_d = pc_q + DW'(INC);
            end
            S_FETCH: begin
                mem_req = 1'b1;
                busy    = 1'b1;
                addr    = pc_q;
                if (mem_rdy) begin
                    ir_d    = D_in;
                    pc_d    = pc_q + DW'(INC);
                    state_d = S_IDLE;
                end else if (TIMEOUT != 0) begin
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                        ferr_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= DW'(RST_PC);
            ir_q    <= '0;
            cnt_q   <= '0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            ferr_q  <= ferr_d;
        end
    end

    assign PC        = pc_q;
    assign IR_out    = ir_q;
    assign fetch_err = ferr_q;

endmodule

// File: tb/tb_cpu_eu_fetch_seq.sv
// Directed self-checking bench for cpu_eu_fetch_seq (DW=16, IMM_W=8, INC=1, TIMEOUT=15, STK_DEPTH=4).
module tb_cpu_eu_fetch_seq;

    logic        clk = 1'b0;
    logic        reset, ir_ld, pc_ld, pc_inc, pc_sel, adr_sel, push, pop, mem_rdy;
    logic [15:0] Alu_out, Reg_out, D_in;
    logic        mem_req, busy, fetch_err, stk_empty, stk_full, stk_err;
    logic [15:0] addr, PC, IR_out;

    int total = 0;
    int bad   = 0;

    cpu_eu_fetch_seq #(
        .DW(16), .IMM_W(8), .RST_PC(0), .INC(1), .TIMEOUT(15), .STK_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .ir_ld(ir_ld), .pc_ld(pc_ld), .pc_inc(pc_inc),
        .pc_sel(pc_sel), .adr_sel(adr_sel), .push(push), .pop(pop),
        .Alu_out(Alu_out), .Reg_out(Reg_out), .D_in(D_in), .mem_rdy(mem_rdy),
        .mem_req(mem_req), .addr(addr), .PC(PC), .IR_out(IR_out), .busy(busy),
        .fetch_err(fetch_err), .stk_empty(stk_empty), .stk_full(stk_full), .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_pc(input logic [15:0] v);
        Alu_out = v; pc_sel = 1'b1; pc_ld = 1'b1;
        tick;
        pc_ld = 1'b0;
    endtask

    task automatic fetch(input logic [15:0] d, input int waits);
        ir_ld = 1'b1;
        tick;
        ir_ld = 1'b0;
        repeat (waits) tick;
        mem_rdy = 1'b1; D_in = d;
        tick;
        mem_rdy = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ir_ld = 0; pc_ld = 0; pc_inc = 0; pc_sel = 0; adr_sel = 0;
        push = 0; pop = 0; mem_rdy = 0; Alu_out = 0; Reg_out = 0; D_in = 0;
        tick; tick;
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pc", 32'(PC), 0);
        chk("rst_ir", 32'(IR_out), 0);
        chk("rst_fetch_err", 32'(fetch_err), 0);
        chk("rst_stk_err", 32'(stk_err), 0);
        chk("rst_stk_empty", 32'(stk_empty), 1);
        chk("rst_stk_full", 32'(stk_full), 0);
        reset = 1'b0;

        adr_sel = 1'b1; Reg_out = 16'h1234; #1;
        chk("idle_addr_reg", 32'(addr), 32'h1234);
        adr_sel = 1'b0; #1;
        chk("idle_addr_pc", 32'(addr), 32'h0000);

        set_pc(16'h0010);
        chk("pc_ld_alu", 32'(PC), 32'h0010);

        // fetch with rdy on the third FETCH cycle; adr_sel/pc_inc/ir_ld must be ignored
        adr_sel = 1'b1;
        ir_ld = 1'b1;
        tick;
        chk("f1_mem_req", 32'(mem_req), 1);
        chk("f1_busy", 32'(busy), 1);
        chk("f1_addr", 32'(addr), 32'h0010);
        pc_inc = 1'b1;
        tick;
        chk("f2_mem_req", 32'(mem_req), 1);
        chk("f2_pc_stable", 32'(PC), 32'h0010);
        pc_inc = 1'b0; ir_ld = 1'b0;
        tick;
        chk("f3_mem_req", 32'(mem_req), 1);
        mem_rdy = 1'b1; D_in = 16'hA5F3;
        tick;
        mem_rdy = 1'b0;
        chk("done_mem_req", 32'(mem_req), 0);
        chk("done_ir", 32'(IR_out), 32'hA5F3);
        chk("done_pc", 32'(PC), 32'h0011);
        chk("done_addr_reg", 32'(addr), 32'h1234);
        adr_sel = 1'b0;

        D_in = 16'hBEEF; mem_rdy = 1'b1;
        tick;
        mem_rdy = 1'b0;
        chk("idle_rdy_ir", 32'(IR_out), 32'hA5F3);
        chk("idle_rdy_busy", 32'(busy), 0);

        // branch back: 0x11 + sext(0xFE) = 0x0F
        set_pc(16'h0010);
        fetch(16'h00FE, 0);
        chk("min_lat_ir", 32'(IR_out), 32'h00FE);
        chk("min_lat_pc", 32'(PC), 32'h0011);
        pc_sel = 1'b0; pc_ld = 1'b1;
        tick;
        pc_ld = 1'b0;
        chk("branch_neg", 32'(PC), 32'h000F);

        // branch forward: 0x11 + 0x7F = 0x90
        set_pc(16'h0010);
        fetch(16'h007F, 1);
        chk("fetch_pc", 32'(PC), 32'h0011);
        pc_sel = 1'b0; pc_ld = 1'b1;
        tick;
        pc_ld = 1'b0;
        chk("branch_pos", 32'(PC), 32'h0090);

        set_pc(16'hFFFF);
        pc_inc = 1'b1;
        tick;
        pc_inc = 1'b0;
        chk("pc_inc_wrap", 32'(PC), 32'h0000);

        Alu_out = 16'h0200; pc_sel = 1'b1; pc_ld = 1'b1; pc_inc = 1'b1;
        tick;
        pc_ld = 1'b0; pc_inc = 1'b0;
        chk("pc_ld_over_inc", 32'(PC), 32'h0200);

        set_pc(16'hFFFF);
        fetch(16'h1234, 2);
        chk("fetch_pc_wrap", 32'(PC), 32'h0000);

        // timeout: 16 FETCH cycles (15 waits + timeout cycle), then error pulse
        ir_ld = 1'b1;
        tick;
        ir_ld = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("to_busy_%0d", i), 32'(busy), 1);
            chk($sformatf("to_noerr_%0d", i), 32'(fetch_err), 0);
            tick;
        end
        chk("to_err_pulse", 32'(fetch_err), 1);
        chk("to_idle", 32'(busy), 0);
        chk("to_pc_keep", 32'(PC), 32'h0000);
        chk("to_ir_keep", 32'(IR_out), 32'h1234);
        tick;
        chk("to_err_clear", 32'(fetch_err), 0);

        // rdy on the timeout cycle completes normally
        ir_ld = 1'b1;
        tick;
        ir_ld = 1'b0;
        repeat (15) tick;
        chk("tc_still_busy", 32'(busy), 1);
        mem_rdy = 1'b1; D_in = 16'h5A5A;
        tick;
        mem_rdy = 1'b0;
        chk("tc_ir", 32'(IR_out), 32'h5A5A);
        chk("tc_pc", 32'(PC), 32'h0001);
        chk("tc_no_err", 32'(fetch_err), 0);
        chk("tc_idle", 32'(busy), 0);

        set_pc(16'h0300);
        ir_ld = 1'b1;
        tick;
        ir_ld = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("midrst_mem_req", 32'(mem_req), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_pc", 32'(PC), 0);
        chk("midrst_ir", 32'(IR_out), 0);

`ifdef LINK_STACK_EN
        set_pc(16'h0001);
        for (int i = 1; i <= 5; i++) begin
            push = 1'b1; pc_ld = 1'b1; pc_sel = 1'b1; Alu_out = 16'(i + 1);
            tick;
        end
        push = 1'b0; pc_ld = 1'b0;
        chk("stk_full", 32'(stk_full), 1);
        chk("stk_not_empty", 32'(stk_empty), 0);
        for (int i = 0; i < 4; i++) begin
            pop = 1'b1;
            tick;
            chk($sformatf("pop_%0d", i), 32'(PC), 32'(5 - i));
            chk($sformatf("pop_noerr_%0d", i), 32'(stk_err), 0);
        end
        pop = 1'b0;
        chk("stk_empty_after", 32'(stk_empty), 1);
        pop = 1'b1;
        tick;
        pop = 1'b0;
        chk("pop_empty_err", 32'(stk_err), 1);
        chk("pop_empty_pc", 32'(PC), 32'h0002);
        tick;
        chk("stk_err_clear", 32'(stk_err), 0);
        push = 1'b1; pop = 1'b1;
        tick;
        push = 1'b0; pop = 1'b0;
        chk("push_pop_err", 32'(stk_err), 1);
        chk("push_pop_empty", 32'(stk_empty), 1);
`else
        set_pc(16'h0042);
        push = 1'b1;
        tick;
        push = 1'b0; pop = 1'b1;
        tick;
        pop = 1'b0;
        chk("nostk_pop_pc", 32'(PC), 32'h0042);
        chk("nostk_err", 32'(stk_err), 0);
        chk("nostk_empty", 32'(stk_empty), 1);
        chk("nostk_full", 32'(stk_full), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
